// File: rtl/rs_alu_scheduler_pkg.sv
// Shared types and constants for the ALU reservation-station scheduler.
package rs_alu_scheduler_pkg;

    localparam int RS_SIZE  = 16;
    localparam int RS_IDX_W = 4;
    localparam int Q_WIDTH  = 5;
    localparam int XLEN     = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic               busy;
        logic [6:0]         opcode;
        logic [2:0]         func3;
        logic [6:0]         func7;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    npc;
        logic [Q_WIDTH-1:0] rob_pos;
        logic [XLEN-1:0]    v1;
        logic [Q_WIDTH-1:0] q1;
        logic               q1_busy;
        logic [XLEN-1:0]    v2;
        logic [Q_WIDTH-1:0] q2;
        logic               q2_busy;
    } rs_entry_t;

endpackage

// File: rtl/rs_alu_scheduler_select.sv
// Lowest-index priority picker; used for both ready-entry select and free-slot search.
module rs_alu_scheduler_select #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_found = |i_vec;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_alu_scheduler.sv
// Reservation station for the single ALU: issue into the lowest free slot, CDB wakeup,
// and lowest-index ready dispatch into a registered EX payload.
module rs_alu_scheduler
    import rs_alu_scheduler_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clr_in,
    input  logic               issue_valid_in,
    input  logic [6:0]         issue_opcode_in,
    input  logic [2:0]         issue_func3_in,
    input  logic [6:0]         issue_func7_in,
    input  logic [XLEN-1:0]    issue_imm_in,
    input  logic [XLEN-1:0]    issue_npc_in,
    input  logic [XLEN-1:0]    issue_v1_in,
    input  logic               issue_q1_busy_in,
    input  logic [Q_WIDTH-1:0] issue_q1_in,
    input  logic [XLEN-1:0]    issue_v2_in,
    input  logic               issue_q2_busy_in,
    input  logic [Q_WIDTH-1:0] issue_q2_in,
    input  logic [Q_WIDTH-1:0] issue_rob_pos_in,
    output logic               rs_full_out,
    input  logic               cdb_valid_in,
    input  logic [Q_WIDTH-1:0] cdb_rob_pos_in,
    input  logic [XLEN-1:0]    cdb_value_in,
    output logic               ex_valid_out,
    output logic [6:0]         ex_opcode_out,
    output logic [2:0]         ex_func3_out,
    output logic [6:0]         ex_func7_out,
    output logic [XLEN-1:0]    ex_v1_out,
    output logic [XLEN-1:0]    ex_v2_out,
    output logic [XLEN-1:0]    ex_imm_out,
    output logic [XLEN-1:0]    ex_npc_out,
    output logic [Q_WIDTH-1:0] ex_rob_pos_out
);

    rs_entry_t r_rs [RS_SIZE];
    rs_entry_t w_rs_nxt [RS_SIZE];
    rs_entry_t w_new;

    logic [RS_SIZE-1:0]  w_busy;
    logic [RS_SIZE-1:0]  w_ready;
    logic                w_sel_found;
    logic [RS_IDX_W-1:0] w_sel_idx;
    logic                w_free_found;
    logic [RS_IDX_W-1:0] w_free_idx;
    logic                w_cdb_hit_q1;
    logic                w_cdb_hit_q2;

    logic               r_ex_valid;
    logic [6:0]         r_ex_opcode;
    logic [2:0]         r_ex_func3;
    logic [6:0]         r_ex_func7;
    logic [XLEN-1:0]    r_ex_v1;
    logic [XLEN-1:0]    r_ex_v2;
    logic [XLEN-1:0]    r_ex_imm;
    logic [XLEN-1:0]    r_ex_npc;
    logic [Q_WIDTH-1:0] r_ex_rob_pos;

    // Busy and ready vectors come from registered state only, so select and full never
    // see same-cycle issue or wakeup.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_busy[i]  = r_rs[i].busy;
            w_ready[i] = r_rs[i].busy & ~r_rs[i].q1_busy & ~r_rs[i].q2_busy;
        end
    end

    assign rs_full_out = &w_busy;

    rs_alu_scheduler_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_sel_ready (
        .i_vec   (w_ready),
        .o_found (w_sel_found),
        .o_idx   (w_sel_idx)
    );

    rs_alu_scheduler_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_sel_free (
        .i_vec   (~w_busy),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    assign w_cdb_hit_q1 = cdb_valid_in && (issue_q1_in == cdb_rob_pos_in);
    assign w_cdb_hit_q2 = cdb_valid_in && (issue_q2_in == cdb_rob_pos_in);

    // Build the incoming entry, forwarding a same-cycle CDB broadcast into its sources.
    always_comb begin
        w_new         = '0;
        w_new.busy    = 1'b1;
        w_new.opcode  = issue_opcode_in;
        w_new.func3   = issue_func3_in;
        w_new.func7   = issue_func7_in;
        w_new.imm     = issue_imm_in;
        w_new.npc     = issue_npc_in;
        w_new.rob_pos = issue_rob_pos_in;
        w_new.q1      = issue_q1_in;
        w_new.q2      = issue_q2_in;
        w_new.v1      = (issue_q1_busy_in && w_cdb_hit_q1) ? cdb_value_in : issue_v1_in;
        w_new.v2      = (issue_q2_busy_in && w_cdb_hit_q2) ? cdb_value_in : issue_v2_in;
        w_new.q1_busy = issue_q1_busy_in && !w_cdb_hit_q1;
        w_new.q2_busy = issue_q2_busy_in && !w_cdb_hit_q2;
    end

    // Next entry state: wakeup on every waiting source, free the dispatched slot, then
    // write the new instruction into the lowest slot that was free in registered state.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_rs_nxt[i] = r_rs[i];
            if (r_rs[i].busy && cdb_valid_in) begin
                if (r_rs[i].q1_busy && (r_rs[i].q1 == cdb_rob_pos_in)) begin
                    w_rs_nxt[i].v1      = cdb_value_in;
                    w_rs_nxt[i].q1_busy = 1'b0;
                end
                if (r_rs[i].q2_busy && (r_rs[i].q2 == cdb_rob_pos_in)) begin
                    w_rs_nxt[i].v2      = cdb_value_in;
                    w_rs_nxt[i].q2_busy = 1'b0;
                end
            end
        end
        if (w_sel_found) begin
            w_rs_nxt[w_sel_idx].busy = 1'b0;
        end
        if (issue_valid_in && w_free_found) begin
            w_rs_nxt[w_free_idx] = w_new;
        end
    end

    // Entry array and dispatch payload registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_rs[i] <= '0;
            end
            r_ex_valid   <= 1'b0;
            r_ex_opcode  <= '0;
            r_ex_func3   <= '0;
            r_ex_func7   <= '0;
            r_ex_v1      <= '0;
            r_ex_v2      <= '0;
            r_ex_imm     <= '0;
            r_ex_npc     <= '0;
            r_ex_rob_pos <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_rs[i] <= '0;
                end
                r_ex_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_rs[i] <= w_rs_nxt[i];
                end
                r_ex_valid <= w_sel_found;
                if (w_sel_found) begin
                    r_ex_opcode  <= r_rs[w_sel_idx].opcode;
                    r_ex_func3   <= r_rs[w_sel_idx].func3;
                    r_ex_func7   <= r_rs[w_sel_idx].func7;
                    r_ex_v1      <= r_rs[w_sel_idx].v1;
                    r_ex_v2      <= r_rs[w_sel_idx].v2;
                    r_ex_imm     <= r_rs[w_sel_idx].imm;
                    r_ex_npc     <= r_rs[w_sel_idx].npc;
                    r_ex_rob_pos <= r_rs[w_sel_idx].rob_pos;
                end
            end
        end
    end

    assign ex_valid_out   = r_ex_valid;
    assign ex_opcode_out  = r_ex_opcode;
    assign ex_func3_out   = r_ex_func3;
    assign ex_func7_out   = r_ex_func7;
    assign ex_v1_out      = r_ex_v1;
    assign ex_v2_out      = r_ex_v2;
    assign ex_imm_out     = r_ex_imm;
    assign ex_npc_out     = r_ex_npc;
    assign ex_rob_pos_out = r_ex_rob_pos;

endmodule
